// File: rtl/tanh_pkg.sv
// Shared constants and types for the tanh segment lookup path.
// Operands are S1.5.6 sign-magnitude: bit 11 sign, bits 10:6 integer, bits 5:0 fraction.
package tanh_pkg;

  localparam int TANH_WIDTH     = 12;
  localparam int TANH_FRAC_BITS = 6;
  localparam int TANH_SIGN_POS  = 11;
  localparam int TANH_INT_MSB   = 10;
  localparam int TANH_INT_LSB   = 6;

  // Default breakpoints, bp[0] in the least significant slot:
  // -2.0, -1.0, -0.5, 0.0, 0.5, 1.0, 2.0
  localparam logic [7*TANH_WIDTH-1:0] TANH_BP_DEFAULT = {
    12'h080, 12'h040, 12'h020, 12'h000, 12'h820, 12'h840, 12'h880
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } seg_state_t;

endpackage

// File: rtl/fixed_point_comparator.sv
// Combinational sign-magnitude fixed-point comparator.
// Negative values sort below positive ones, so -0 is strictly below +0.
module fixed_point_comparator
  import tanh_pkg::*;
#(
  parameter int WIDTH     = TANH_WIDTH,
  parameter int FRAC_BITS = TANH_FRAC_BITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gte_b,
  output logic             a_eq_b
);

  logic                      sign_a, sign_b;
  logic [WIDTH-2:FRAC_BITS]  int_a, int_b;
  logic [FRAC_BITS-1:0]      frac_a, frac_b;
  logic                      mag_gt, mag_eq, a_gt_b;

  assign sign_a = a[WIDTH-1];
  assign sign_b = b[WIDTH-1];
  assign int_a  = a[WIDTH-2:FRAC_BITS];
  assign int_b  = b[WIDTH-2:FRAC_BITS];
  assign frac_a = a[FRAC_BITS-1:0];
  assign frac_b = b[FRAC_BITS-1:0];

  // Integer field decides first; fraction only breaks integer ties.
  assign mag_gt = (int_a > int_b) || ((int_a == int_b) && (frac_a > frac_b));
  assign mag_eq = (int_a == int_b) && (frac_a == frac_b);

  assign a_eq_b = (sign_a == sign_b) && mag_eq;
  assign a_gt_b = (!sign_a &&  sign_b)
               || (!sign_a && !sign_b && mag_gt)
               || ( sign_a &&  sign_b && !mag_gt && !mag_eq);
  assign a_gte_b = a_gt_b || a_eq_b;

endmodule

// File: rtl/tanh_segment_locator.sv
// Binary search for the tanh segment containing x: one breakpoint compare per cycle,
// result is the number of breakpoints x is greater than or equal to.
module tanh_segment_locator
  import tanh_pkg::*;
#(
  parameter int WIDTH     = TANH_WIDTH,
  parameter int FRAC_BITS = TANH_FRAC_BITS,
  parameter int LOG_SEG   = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_x,
  input  logic [(2**LOG_SEG-1)*WIDTH-1:0]   bp_flat,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LOG_SEG-1:0]                out_seg,
  output logic [WIDTH-1:0]                  out_x,
  output logic                              out_hit
);

  localparam int NUM_BP   = 2**LOG_SEG - 1;
  localparam int NUM_SLOT = 2**LOG_SEG;

  seg_state_t           state_reg, state_next;
  logic [LOG_SEG-1:0]   lo_reg, lo_next;
  logic [LOG_SEG-1:0]   step_reg, step_next;
  logic [WIDTH-1:0]     x_reg, x_next;
  logic                 hit_reg, hit_next;
  logic [LOG_SEG-1:0]   half, mid;
  logic                 last_step;
  logic [WIDTH-1:0]     bp_slot [NUM_SLOT];
  logic [WIDTH-1:0]     bp_mid;
  logic                 a_gte_b, a_eq_b;

  // Pad the table to a power of two so any mid value selects a defined entry.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOT; gi++) begin : g_bp_slot
      if (gi < NUM_BP) begin : g_real
        assign bp_slot[gi] = bp_flat[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign bp_slot[gi] = '0;
      end
    end
  endgenerate

  assign half      = LOG_SEG'(1) << (LOG_SEG'(LOG_SEG-1) - step_reg);
  assign mid       = lo_reg + half - LOG_SEG'(1);
  assign last_step = (step_reg == LOG_SEG'(LOG_SEG-1));
  assign bp_mid    = bp_slot[mid];

  fixed_point_comparator #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_cmp (
    .a       (x_reg),
    .b       (bp_mid),
    .a_gte_b (a_gte_b),
    .a_eq_b  (a_eq_b)
  );

  assign in_ready  = (state_reg == ST_IDLE) && !rst;
  assign out_valid = (state_reg == ST_DONE);
  assign out_seg   = lo_reg;
  assign out_x     = x_reg;
  assign out_hit   = hit_reg;

  always_comb begin
    state_next = state_reg;
    lo_next    = lo_reg;
    step_next  = step_reg;
    x_next     = x_reg;
    hit_next   = hit_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          x_next     = in_x;
          lo_next    = '0;
          step_next  = '0;
          hit_next   = 1'b0;
          state_next = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (a_gte_b) lo_next = mid + LOG_SEG'(1);
        hit_next  = hit_reg | a_eq_b;
        step_next = step_reg + LOG_SEG'(1);
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      lo_reg    <= '0;
      step_reg  <= '0;
      x_reg     <= '0;
      hit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      lo_reg    <= lo_next;
      step_reg  <= step_next;
      x_reg     <= x_next;
      hit_reg   <= hit_next;
    end
  end

endmodule

// File: tb/tb_tanh_segment_locator.sv
// Randomised and directed bench for tanh_segment_locator against a
// key-ordering reference model of the breakpoint count.
module tb_tanh_segment_locator;

  localparam int W  = 12;
  localparam int LS = 3;
  localparam int NB = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_x;
  logic [NB*W-1:0] bp_flat;
  logic            out_valid;
  logic            out_ready;
  logic [LS-1:0]   out_seg;
  logic [W-1:0]    out_x;
  logic            out_hit;

  logic [W-1:0]    bp_tb [NB];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tanh_segment_locator #(.WIDTH(W), .FRAC_BITS(6), .LOG_SEG(LS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .bp_flat   (bp_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seg   (out_seg),
    .out_x     (out_x),
    .out_hit   (out_hit)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Map a sign-magnitude value onto a monotonic integer line (-0 just below +0).
  function automatic int key_of(input logic [W-1:0] v);
    if (v[W-1]) return 2047 - int'(v[W-2:0]);
    return 2048 + int'(v[W-2:0]);
  endfunction

  function automatic logic [W-1:0] val_of(input int k);
    logic [W-1:0] v;
    if (k >= 2048) v = {1'b0, 11'(k - 2048)};
    else v = {1'b1, 11'(2047 - k)};
    return v;
  endfunction

  task automatic model(input logic [W-1:0] x, output int seg, output int hit);
    seg = 0;
    hit = 0;
    for (int i = 0; i < NB; i++) begin
      if (key_of(x) >= key_of(bp_tb[i])) seg++;
      if (key_of(x) == key_of(bp_tb[i])) hit = 1;
    end
  endtask

  task automatic pack_bp();
    for (int i = 0; i < NB; i++) bp_flat[i*W +: W] = bp_tb[i];
  endtask

  task automatic load_default();
    bp_tb[0] = 12'h880; bp_tb[1] = 12'h840; bp_tb[2] = 12'h820; bp_tb[3] = 12'h000;
    bp_tb[4] = 12'h020; bp_tb[5] = 12'h040; bp_tb[6] = 12'h080;
    pack_bp();
  endtask

  task automatic load_random_sorted();
    int keys [NB];
    int t;
    for (int i = 0; i < NB; i++) keys[i] = int'($urandom_range(0, 4095));
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NB - 1 - i; j++)
        if (keys[j] > keys[j+1]) begin
          t = keys[j]; keys[j] = keys[j+1]; keys[j+1] = t;
        end
    for (int i = 0; i < NB; i++) bp_tb[i] = val_of(keys[i]);
    pack_bp();
  endtask

  task automatic run_op(input logic [W-1:0] x, input int stall, input int exp_seg, input int exp_hit);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_idle", int'(in_ready), 1);
    out_ready = (stall == 0);
    in_valid  = 1'b1;
    in_x      = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x     = W'($urandom);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", n, LS);
    check_eq("seg", int'(out_seg), exp_seg);
    check_eq("hit", int'(out_hit), exp_hit);
    check_eq("x_echo", int'(out_x), int'(x));
    check_eq("in_ready_busy", int'(in_ready), 0);
    for (int s = 0; s < stall; s++) begin
      if (s == 1) begin
        in_valid = 1'b1;
        in_x     = ~x;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("hold_valid", int'(out_valid), 1);
      check_eq("hold_seg", int'(out_seg), exp_seg);
      check_eq("hold_x", int'(out_x), int'(x));
      check_eq("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    if (stall > 0) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check_eq("post_hs_valid", int'(out_valid), 0);
    check_eq("post_hs_ready", int'(in_ready), 1);
    $display("op x=%h stall=%0d seg=%0d hit=%0d exp_seg=%0d exp_hit=%0d",
             x, stall, out_seg, out_hit, exp_seg, exp_hit);
  endtask

  typedef struct { logic [W-1:0] x; int seg; int hit; } dir_t;
  dir_t dir_tab [7];

  initial begin
    int s, h;
    logic [W-1:0] rx;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    load_default();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_seg", int'(out_seg), 0);
    check_eq("rst_out_hit", int'(out_hit), 0);
    check_eq("rst_out_x", int'(out_x), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rel_in_ready", int'(in_ready), 1);

    dir_tab[0] = '{12'h030, 5, 0};
    dir_tab[1] = '{12'h040, 6, 1};
    dir_tab[2] = '{12'h000, 4, 1};
    dir_tab[3] = '{12'h8C0, 0, 0};
    dir_tab[4] = '{12'h0C0, 7, 0};
    dir_tab[5] = '{12'h880, 1, 1};
    dir_tab[6] = '{12'h800, 3, 0};
    foreach (dir_tab[i]) run_op(dir_tab[i].x, 0, dir_tab[i].seg, dir_tab[i].hit);

    run_op(12'h030, 5, 5, 0);

    // Abort a search with reset one cycle after acceptance.
    @(negedge clk);
    in_valid = 1'b1;
    in_x     = 12'h030;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("abort_out_valid", int'(out_valid), 0);
    check_eq("abort_in_ready", int'(in_ready), 0);
    check_eq("abort_out_seg", int'(out_seg), 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort_held_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(12'hFFF, 0, 0, 0);

    for (int t = 0; t < 4; t++) begin
      if (t > 0) load_random_sorted();
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 2) == 0) rx = bp_tb[$urandom_range(0, NB-1)];
        else rx = W'($urandom);
        model(rx, s, h);
        run_op(rx, int'($urandom_range(0, 2)), s, h);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
